// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, video and debug request/return signals plus the shared memory port.
// slave is the arbiter's view; master is the view of the requesters and the memory.
interface dmem_arbiter_if #(parameter int AW = 8, parameter int DW = 32);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_gnt;
    logic          vid_rvalid;
    logic [DW-1:0] vid_rdata;
    logic          dbg_req;
    logic [AW-1:0] dbg_addr;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, dbg_req, dbg_addr, mem_rdata,
        output cpu_stall, cpu_rvalid, cpu_rdata, vid_gnt, vid_rvalid, vid_rdata,
               dbg_gnt, dbg_rvalid, dbg_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, dbg_req, dbg_addr, mem_rdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata, vid_gnt, vid_rvalid, vid_rdata,
               dbg_gnt, dbg_rvalid, dbg_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: per-cycle arbiter of one synchronous memory port between CPU, video and debug.
// Priority: starved video > CPU > video/debug round-robin; reads return one cycle later.
module dmem_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 32,
    parameter int MAXWAIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VID, OWN_DBG} own_e;
    own_e          own_q, own_d;
    logic          ptr_q, ptr_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] vid_rdata_q, vid_rdata_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
    logic [AW-1:0] addr_sel;
    logic          force_v, cpu_g, vid_g, dbg_g;
    // grants are gated by rst so every combinational output is 0 while reset is held
    always_comb begin
        force_v     = rst && bus.vid_req && cnt_q == 4'(MAXWAIT);
        cpu_g       = rst && bus.cpu_req && !force_v;
        vid_g       = force_v || (rst && !bus.cpu_req && bus.vid_req && (!bus.dbg_req || !ptr_q));
        dbg_g       = rst && !force_v && !bus.cpu_req && bus.dbg_req && (!bus.vid_req || ptr_q);
        ptr_d       = vid_g ? 1'b1 : dbg_g ? 1'b0 : ptr_q;
        cnt_d       = (bus.vid_req && !vid_g) ? (cnt_q == 4'(MAXWAIT) ? cnt_q : cnt_q + 4'd1) : 4'd0;
        own_d       = (cpu_g && !bus.cpu_we) ? OWN_CPU : vid_g ? OWN_VID : dbg_g ? OWN_DBG : OWN_NONE;
        addr_sel    = cpu_g ? bus.cpu_addr : vid_g ? bus.vid_addr : dbg_g ? bus.dbg_addr : '0;
        cpu_rdata_d = own_q == OWN_CPU ? bus.mem_rdata : cpu_rdata_q;
        vid_rdata_d = own_q == OWN_VID ? bus.mem_rdata : vid_rdata_q;
        dbg_rdata_d = own_q == OWN_DBG ? bus.mem_rdata : dbg_rdata_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            own_q       <= OWN_NONE;
            ptr_q       <= 1'b0;
            cnt_q       <= 4'd0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            own_q       <= own_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_rdata_q <= vid_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end
    assign bus.cpu_stall  = rst && bus.cpu_req && !cpu_g;
    assign bus.vid_gnt    = vid_g;
    assign bus.dbg_gnt    = dbg_g;
    assign bus.mem_en     = cpu_g || vid_g || dbg_g;
    assign bus.mem_we     = cpu_g && bus.cpu_we;
    assign bus.mem_addr   = addr_sel;
    assign bus.mem_wdata  = cpu_g ? bus.cpu_wdata : '0;
    assign bus.cpu_rvalid = own_q == OWN_CPU;
    assign bus.vid_rvalid = own_q == OWN_VID;
    assign bus.dbg_rvalid = own_q == OWN_DBG;
    assign bus.cpu_rdata  = cpu_rdata_d;
    assign bus.vid_rdata  = vid_rdata_d;
    assign bus.dbg_rdata  = dbg_rdata_d;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors against dmem_arbiter with a small synchronous memory model.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;
    logic [31:0] mem [256];
    always #5 clk = ~clk;
    dmem_arbiter_if #(.AW(8), .DW(32)) bus ();
    dmem_arbiter #(.AW(8), .DW(32), .MAXWAIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    // word a holds 0xA00000aa, except 0x10 which holds 5
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
            mem[16] <= 32'd5;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else bus.mem_rdata <= mem[bus.mem_addr];
        end
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic set_in(input logic cr, input logic cw, input logic [7:0] ca, input logic [31:0] cd,
                          input logic vr, input logic [7:0] va, input logic dr, input logic [7:0] da);
        bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
        bus.vid_req = vr; bus.vid_addr = va; bus.dbg_req = dr; bus.dbg_addr = da;
    endtask
    task automatic cyc(input logic cr, input logic cw, input logic [7:0] ca, input logic [31:0] cd,
                       input logic vr, input logic [7:0] va, input logic dr, input logic [7:0] da);
        @(posedge clk);
        #1;
        set_in(cr, cw, ca, cd, vr, va, dr, da);
        #1;
    endtask
    initial begin
        bus.mem_rdata = '0;
        set_in(1, 1, 8'h10, 32'h1234, 1, 8'h30, 1, 8'h31);
        #2;
        chk("rst_vid_gnt", 32'(bus.vid_gnt), 0);
        chk("rst_dbg_gnt", 32'(bus.dbg_gnt), 0);
        chk("rst_stall", 32'(bus.cpu_stall), 0);
        chk("rst_mem_en", 32'(bus.mem_en), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 0);
        repeat (2) @(posedge clk);
        #1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        // single CPU read of address 0x10
        cyc(1, 0, 8'h10, 0, 0, 0, 0, 0);
        chk("rd_mem_en", 32'(bus.mem_en), 1);
        chk("rd_mem_addr", 32'(bus.mem_addr), 32'h10);
        chk("rd_mem_we", 32'(bus.mem_we), 0);
        chk("rd_stall", 32'(bus.cpu_stall), 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rd_rvalid", 32'(bus.cpu_rvalid), 1);
        chk("rd_rdata", bus.cpu_rdata, 32'd5);
        chk("rd_idle_en", 32'(bus.mem_en), 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rd_rvalid_off", 32'(bus.cpu_rvalid), 0);
        chk("rd_rdata_hold", bus.cpu_rdata, 32'd5);
        // video/debug round-robin starting from video
        for (int i = 0; i < 5; i++) begin
            if (i < 4) cyc(0, 0, 0, 0, 1, 8'h30, 1, 8'h31);
            else cyc(0, 0, 0, 0, 0, 0, 0, 0);
            if (i < 4) begin
                chk($sformatf("rr_vid_gnt%0d", i), 32'(bus.vid_gnt), 32'(i % 2 == 0));
                chk($sformatf("rr_dbg_gnt%0d", i), 32'(bus.dbg_gnt), 32'(i % 2 == 1));
            end
            if (i > 0) begin
                chk($sformatf("rr_vid_rv%0d", i), 32'(bus.vid_rvalid), 32'((i - 1) % 2 == 0));
                chk($sformatf("rr_dbg_rv%0d", i), 32'(bus.dbg_rvalid), 32'((i - 1) % 2 == 1));
                if ((i - 1) % 2 == 0) chk($sformatf("rr_vid_rd%0d", i), bus.vid_rdata, 32'hA000_0030);
                else chk($sformatf("rr_dbg_rd%0d", i), bus.dbg_rdata, 32'hA000_0031);
            end
        end
        // CPU vs video: four CPU grants then a forced video grant, twice
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 8'h11, 0, 1, 8'h30, 0, 0);
            chk($sformatf("sv_vid_gnt%0d", i), 32'(bus.vid_gnt), 32'(i % 5 == 4));
            chk($sformatf("sv_stall%0d", i), 32'(bus.cpu_stall), 32'(i % 5 == 4));
            if (i > 0) chk($sformatf("sv_cpu_rv%0d", i), 32'(bus.cpu_rvalid), 32'((i - 1) % 5 != 4));
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("sv_vid_rv_last", 32'(bus.vid_rvalid), 1);
        chk("sv_vid_rd_last", bus.vid_rdata, 32'hA000_0030);
        // CPU write then debug read-back
        cyc(1, 1, 8'h20, 32'hDEAD_BEEF, 0, 0, 0, 0);
        chk("wr_mem_we", 32'(bus.mem_we), 1);
        chk("wr_mem_en", 32'(bus.mem_en), 1);
        chk("wr_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        chk("wr_mem_addr", 32'(bus.mem_addr), 32'h20);
        cyc(0, 0, 0, 0, 0, 0, 1, 8'h20);
        chk("wr_no_rvalid", 32'(bus.cpu_rvalid), 0);
        chk("wr_dbg_gnt", 32'(bus.dbg_gnt), 1);
        chk("wr_dbg_we", 32'(bus.mem_we), 0);
        chk("wr_dbg_wdata", bus.mem_wdata, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("wr_dbg_rv", 32'(bus.dbg_rvalid), 1);
        chk("wr_dbg_rd", bus.dbg_rdata, 32'hDEAD_BEEF);
        chk("wr_cpu_rv2", 32'(bus.cpu_rvalid), 0);
        // all three requests: CPU wins and the pointer stays on video
        cyc(1, 0, 8'h12, 0, 1, 8'h30, 1, 8'h31);
        chk("all_mem_addr", 32'(bus.mem_addr), 32'h12);
        chk("all_vid_gnt", 32'(bus.vid_gnt), 0);
        chk("all_dbg_gnt", 32'(bus.dbg_gnt), 0);
        chk("all_stall", 32'(bus.cpu_stall), 0);
        cyc(0, 0, 0, 0, 1, 8'h30, 1, 8'h31);
        chk("all_ptr_vid", 32'(bus.vid_gnt), 1);
        chk("all_ptr_dbg", 32'(bus.dbg_gnt), 0);
        chk("all_cpu_rd", bus.cpu_rdata, 32'hA000_0012);
        // video grant aborted by a reset pulse before its return edge
        cyc(0, 0, 0, 0, 1, 8'h30, 0, 0);
        chk("ab_vid_gnt", 32'(bus.vid_gnt), 1);
        #2;
        rst = 1'b0;
        set_in(1, 1, 8'h40, 32'h55, 1, 8'h30, 1, 8'h31);
        #1;
        chk("ab_rst_vid_rv", 32'(bus.vid_rvalid), 0);
        chk("ab_rst_vid_rd", bus.vid_rdata, 0);
        chk("ab_rst_mem_en", 32'(bus.mem_en), 0);
        chk("ab_rst_stall", 32'(bus.cpu_stall), 0);
        chk("ab_rst_wdata", bus.mem_wdata, 0);
        @(posedge clk);
        #1;
        chk("ab_rst_vid_rv2", 32'(bus.vid_rvalid), 0);
        chk("ab_rst_mem_addr", 32'(bus.mem_addr), 0);
        set_in(0, 0, 0, 0, 1, 8'h30, 1, 8'h31);
        rst = 1'b1;
        #1;
        chk("ab_post_vid_rv", 32'(bus.vid_rvalid), 0);
        chk("ab_post_ptr_vid", 32'(bus.vid_gnt), 1);
        chk("ab_post_ptr_dbg", 32'(bus.dbg_gnt), 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("ab_post_vid_rv2", 32'(bus.vid_rvalid), 1);
        chk("ab_post_vid_rd", bus.vid_rdata, 32'hA000_0030);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
